// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit, XLEN-parametrised.
// Iterative shift-add multiply and restoring radix-2 divide, one bit per
// cycle, followed by a single sign-fix cycle. Divide-by-zero and signed
// overflow are resolved at accept time without iterating.
// Optional build macro: MULDIV_FAST_MUL_EN -- the four multiply ops use one
// combinational signed multiply at accept and complete in a single cycle.
//
// Handshake: a request is accepted on a rising edge with in_valid & in_ready
// (in_ready is high only while idle); a result completes on a rising edge
// with out_valid & out_ready, and result is held stable until then. kill
// returns the unit to idle on the next edge and outranks both handshakes.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      funct3,
   input  logic            kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(XLEN - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        op;
   logic              a_neg_q;
   logic              b_neg_q;
   // Multiply: {high partial sum, low product bits}.
   // Divide:   {partial remainder, dividend bits shifting into quotient}.
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opnd;     // multiplicand |a| or divisor |b|
   logic [XLEN-1:0]   mplier;   // remaining multiplier bits

   // Accept-time decode
   logic              is_div;
   logic              sign_a;
   logic              sign_b;
   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   abs_a;
   logic [XLEN-1:0]   abs_b;
   logic              div_zero;
   logic              div_ovf;
   logic [XLEN-1:0]   special_res;

   // Iteration datapath
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_sh;
   logic [XLEN:0]     div_diff;
   logic              div_ok;

   // Sign fix
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   fix_res;

`ifdef MULDIV_FAST_MUL_EN
   logic signed [2*XLEN+1:0] fast_a;
   logic signed [2*XLEN+1:0] fast_b;
   logic signed [2*XLEN+1:0] fast_p;
   logic [XLEN-1:0]          fast_res;
`endif

   assign in_ready  = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign out_valid = (state == S_DONE);

   // Decode the incoming request: operand signedness, magnitudes, special divides
   always_comb begin
      is_div   = funct3[2];
      sign_a   = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
      sign_b   = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
      a_neg    = sign_a & a[XLEN-1];
      b_neg    = sign_b & b[XLEN-1];
      abs_a    = a_neg ? -a : a;
      abs_b    = b_neg ? -b : b;
      div_zero = is_div && (b == '0);
      div_ovf  = is_div && !funct3[0] && (a == MIN_VAL) && (b == '1);
      // funct3[1] selects remainder over quotient
      if (div_zero) begin
         special_res = funct3[1] ? a : '1;
      end else begin
         special_res = funct3[1] ? '0 : MIN_VAL;
      end
   end

   // One multiply add-shift step and one restoring divide step
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (mplier[0] ? {1'b0, opnd} : '0);
      div_sh   = acc[2*XLEN-1:XLEN-1];
      div_diff = div_sh - {1'b0, opnd};
      div_ok   = ~div_diff[XLEN];
   end

   // Apply operand signs to the unsigned result and pick the output field
   always_comb begin
      prod = (a_neg_q ^ b_neg_q) ? -acc : acc;
      quo  = (a_neg_q ^ b_neg_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem  = a_neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      case (op)
         3'd0:             fix_res = prod[XLEN-1:0];
         3'd1, 3'd2, 3'd3: fix_res = prod[2*XLEN-1:XLEN];
         3'd4, 3'd5:       fix_res = quo;
         default:          fix_res = rem;
      endcase
   end

`ifdef MULDIV_FAST_MUL_EN
   // Single-cycle signed (XLEN+1)x(XLEN+1) multiply covering all four mul ops
   always_comb begin
      fast_a   = {{(XLEN+2){a_neg}}, a};
      fast_b   = {{(XLEN+2){b_neg}}, b};
      fast_p   = fast_a * fast_b;
      fast_res = (funct3 == 3'd0) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
   end
`endif

   // Control FSM and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         op      <= '0;
         a_neg_q <= 1'b0;
         b_neg_q <= 1'b0;
         acc     <= '0;
         opnd    <= '0;
         mplier  <= '0;
         result  <= '0;
      end else if (kill) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op      <= funct3;
                  a_neg_q <= a_neg;
                  b_neg_q <= b_neg;
                  mplier  <= abs_b;
                  opnd    <= is_div ? abs_b : abs_a;
                  // The divider shifts the dividend out of the low half
                  acc     <= is_div ? {{XLEN{1'b0}}, abs_a} : '0;
                  if (div_zero || div_ovf) begin
                     result <= special_res;
                     state  <= S_DONE;
                  end else if (is_div) begin
                     cnt   <= CNT_START;
                     state <= S_DIV;
                  end else begin
`ifdef MULDIV_FAST_MUL_EN
                     result <= fast_res;
                     state  <= S_DONE;
`else
                     cnt   <= CNT_START;
                     state <= S_MUL;
`endif
                  end
               end
            end
            S_MUL: begin
               acc    <= {mul_sum, acc[XLEN-1:1]};
               mplier <= mplier >> 1;
               if (cnt == '0) begin
                  state <= S_FIX;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_DIV: begin
               acc <= {(div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc[XLEN-2:0], div_ok};
               if (cnt == '0) begin
                  state <= S_FIX;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_FIX: begin
               result <= fix_res;
               state  <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M multiply/divide unit, XLEN-parametrised, replacing the single-cycle combinational MUL/DIV/REM paths in the ALU. It sits beside the ALU in the execute stage. The pipeline issues an operation on the input handshake and stalls until the result handshake completes. The unit covers all eight RV32M funct3 operations, including the high-half multiplies the ALU does not provide, with RISC-V-exact divide-by-zero and overflow results.

## Interface
- XLEN, 32: operand/result width; even, ≥ 8.
- CNT_W, $clog2(XLEN)+1: iteration counter width (derived, not overridden).

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE; accept = in_valid & in_ready at a rising edge.
- a  in  XLEN  rs1 operand (dividend / multiplicand).
- b  in  XLEN  rs2 operand (divisor / multiplier).
- funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- kill  in  1  abort in-flight op (pipeline flush).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result; complete = out_valid & out_ready.
- result  out  XLEN  registered result, stable while out_valid & !out_ready.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE → accept: latch funct3 and the operand signs. Store |a| and |b| for signed ops (DIV/REM: both signed; MULH: both signed; MULHSU: a signed, b unsigned). Clear the 2·XLEN accumulator.
  - DIV/DIVU/REM/REMU with b==0 → DONE directly. Quotient = all-ones; remainder = a.
  - DIV/REM with a==MIN (1 followed by XLEN-1 zeros) and b==all-ones → DONE directly. Quotient = MIN; remainder = 0.
  - Other div ops → DIV. Mul ops → MUL, or DONE under the fast-mul config.
- MUL: shift-add, one multiplier bit per cycle, XLEN cycles, → FIX.
- DIV: restoring radix-2, one quotient bit per cycle, XLEN cycles, → FIX.
- FIX: one cycle.
  - Negate the product if the operand signs differ.
  - Negate the quotient if the dividend and divisor signs differ.
  - Negate the remainder if the dividend is negative.
  - Select the output: low half for MUL, high half for MULH*, quotient or remainder per funct3.
  - Register result, → DONE.
- DONE: out_valid=1. Complete → IDLE. Hold while out_ready=0.
- kill, any state: → IDLE next edge, out_valid=0, result unchanged. kill has priority over accept and complete in the same cycle.
- in_valid while busy: ignored, no queuing.
- Counter counts XLEN-1 down to 0; state leaves on the edge where the count is 0.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, result=0, state IDLE, counter 0.
- rst in the same cycle as accept or kill: rst wins.
- Reset mid-operation discards the op with no out_valid.
- Latency, accept edge to first cycle with out_valid=1:
  - iterative MUL and DIV: XLEN+2 cycles (34 at XLEN=32);
  - special-case div: 1 cycle;
  - fast MUL: 1 cycle.
- Throughput: next accept is possible one cycle after completion. in_ready rises the cycle after the complete edge.
- No combinational path from any input to any output. in_ready, out_valid, busy and result are registered or state-decoded.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - the four MUL ops use a single combinational (XLEN+1)×(XLEN+1) signed multiply at accept;
  - they register straight into result and skip MUL and FIX, for a latency of 1;
  - the MUL state is unreachable.
- Undefined: iterative shift-add path, latency XLEN+2. Divide behaviour is identical in both builds.

## Test plan
- DIV a=42, b=6, out_ready=1 → out_valid after 34 cycles, result=7, then in_ready=1 next cycle. REM a=-43, b=6 → result=-1 (0xFFFFFFFF).
- Divide by zero: DIVU a=42, b=0 → 0xFFFFFFFF after 1 cycle. REMU a=42, b=0 → 42.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000. REM with the same operands → 0. Both after 1 cycle.
- MULH a=0x80000000, b=0x80000000 → 0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF. MULHU with the same operands → 0xFFFFFFFE. MUL 7*6 → 42. Check latency 34 or 1 depending on the build.
- Backpressure and flush:
  - out_ready=0 for 5 cycles after DONE → result and out_valid held stable, in_ready=0;
  - kill at iteration 10 → no out_valid, in_ready=1 next cycle, next op correct;
  - rst mid-DIV → all outputs return to their reset values.
- Parameter sweep XLEN=8 and XLEN=16: random signed and unsigned ops vs reference model, latency XLEN+2.
